// File: rtl/half_adder_pkg.sv
// Shared constants, lane-vector type and saturating-increment helper for half_adder_lanes.
// The HALF_ADDER_STATS_EN build option uses the helper for its carry-event counter.
package half_adder_pkg;

   localparam int DEFAULT_WIDTH = 1;
   localparam int DEFAULT_CNT_W = 16;
   localparam int MAX_WIDTH     = 64;

   typedef logic [MAX_WIDTH-1:0] lane_vec_t;

   // Increment a w-bit value held in 64 bits, sticking at all-ones of that width.
   function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned w);
      logic [63:0] max_val;
      max_val = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (val >= max_val) ? max_val : val + 64'd1;
   endfunction

endpackage

// File: rtl/half_adder_bit.sv
// Purely combinational 1-bit half-adder cell: s = a ^ b, c = a & b.
module half_adder_bit (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/half_adder_lanes.sv
// WIDTH independent half adders with registered sum/carry and a valid flag.
// Define HALF_ADDER_STATS_EN to add the saturating carry_cnt event counter.
module half_adder_lanes
   import half_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic             carry_any
`ifdef HALF_ADDER_STATS_EN
   ,
   output logic [CNT_W-1:0] carry_cnt
`endif
);

   if (WIDTH < 1 || WIDTH > MAX_WIDTH || CNT_W < 1 || CNT_W > 64) begin : g_bad_param
      $error("half_adder_lanes: WIDTH must be 1..64 and CNT_W 1..64");
   end

   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] carry_next;
   lane_vec_t        carry_wide;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_bit u_bit (
         .a (in_a[i]),
         .b (in_b[i]),
         .s (sum_next[i]),
         .c (carry_next[i])
      );
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         carry     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum   <= sum_next;
            carry <= carry_next;
         end
      end
   end

   assign carry_wide = lane_vec_t'(carry);
   assign carry_any  = |carry_wide;

`ifdef HALF_ADDER_STATS_EN
   // Counts accepted cycles with a carry in the incoming operands, not the registered ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_cnt <= '0;
      end else if (in_valid && (|carry_next)) begin
         carry_cnt <= CNT_W'(sat_inc(64'(carry_cnt), CNT_W));
      end
   end
`endif

endmodule

// File: tb/tb_half_adder_lanes.sv
// Directed bench for half_adder_lanes: a WIDTH=1 and a WIDTH=8/CNT_W=2 instance side by side.
// Counter checks run only when HALF_ADDER_STATS_EN is defined.
module tb_half_adder_lanes;

   logic       clk;
   logic       rst_n;
   logic       v1, v8;
   logic       a1, b1;
   logic [7:0] a8, b8;
   logic       ov1, ov8;
   logic       s1, c1, any1, any8;
   logic [7:0] s8, c8;
`ifdef HALF_ADDER_STATS_EN
   logic [15:0] cnt1;
   logic [1:0]  cnt8;
`endif

   int n_total = 0;
   int n_pass  = 0;

   half_adder_lanes #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v1),
      .in_a      (a1),
      .in_b      (b1),
      .out_valid (ov1),
      .sum       (s1),
      .carry     (c1),
      .carry_any (any1)
`ifdef HALF_ADDER_STATS_EN
      ,
      .carry_cnt (cnt1)
`endif
   );

   half_adder_lanes #(.WIDTH(8), .CNT_W(2)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v8),
      .in_a      (a8),
      .in_b      (b8),
      .out_valid (ov8),
      .sum       (s8),
      .carry     (c8),
      .carry_any (any8)
`ifdef HALF_ADDER_STATS_EN
      ,
      .carry_cnt (cnt8)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a8, b8, s8, c8;
      logic       any8;
      logic       a1, b1, s1, c1, any1;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, " ov1"},  64'(ov1),  64'd0);
      check({tag, " s1"},   64'(s1),   64'd0);
      check({tag, " c1"},   64'(c1),   64'd0);
      check({tag, " any1"}, 64'(any1), 64'd0);
      check({tag, " ov8"},  64'(ov8),  64'd0);
      check({tag, " s8"},   64'(s8),   64'd0);
      check({tag, " c8"},   64'(c8),   64'd0);
      check({tag, " any8"}, 64'(any8), 64'd0);
`ifdef HALF_ADDER_STATS_EN
      check({tag, " cnt1"}, 64'(cnt1), 64'd0);
      check({tag, " cnt8"}, 64'(cnt8), 64'd0);
`endif
   endtask

   initial begin
      //             a8     b8     s8     c8     any8  a1    b1    s1    c1    any1
      vecs[0] = '{8'hF0, 8'hCC, 8'h3C, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h0F, 8'h30, 8'h3F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'hAA, 8'h55, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{8'h81, 8'h01, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset held with live random stimulus
      rst_n = 1'b0;
      v1 = 1'b1; v8 = 1'b1;
      a1 = 1'($urandom); b1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      step();
      a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1;
      step();
      check_cleared("reset");
      v1 = 1'b0; v8 = 1'b0;
      rst_n = 1'b1;
      step();

      // Table: one-cycle latency, lane independence, WIDTH=1 exhaustive
      for (int i = 0; i < 5; i++) begin
         v1 = 1'b1; v8 = 1'b1;
         a1 = vecs[i].a1; b1 = vecs[i].b1;
         a8 = vecs[i].a8; b8 = vecs[i].b8;
         step();
         check($sformatf("vec%0d ov1", i),  64'(ov1),  64'd1);
         check($sformatf("vec%0d s1", i),   64'(s1),   64'(vecs[i].s1));
         check($sformatf("vec%0d c1", i),   64'(c1),   64'(vecs[i].c1));
         check($sformatf("vec%0d any1", i), 64'(any1), 64'(vecs[i].any1));
         check($sformatf("vec%0d ov8", i),  64'(ov8),  64'd1);
         check($sformatf("vec%0d s8", i),   64'(s8),   64'(vecs[i].s8));
         check($sformatf("vec%0d c8", i),   64'(c8),   64'(vecs[i].c8));
         check($sformatf("vec%0d any8", i), 64'(any8), 64'(vecs[i].any8));
      end

      // Hold on idle
      a1 = 1'b1; b1 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      step();
      v1 = 1'b0; v8 = 1'b0;
      a1 = 1'b0; b1 = 1'b1; a8 = 8'h00; b8 = 8'h01;
      step();
      check("idle ov1", 64'(ov1), 64'd0);
      check("idle s1",  64'(s1),  64'd0);
      check("idle c1",  64'(c1),  64'd1);
      check("idle ov8", 64'(ov8), 64'd0);
      check("idle s8",  64'(s8),  64'h00);
      check("idle c8",  64'(c8),  64'h01);
      step();
      check("idle2 c1",   64'(c1),   64'd1);
      check("idle2 any8", 64'(any8), 64'd1);

      // Reset mid-stream, asserted between edges
      v1 = 1'b1; v8 = 1'b1;
      a1 = 1'b1; b1 = 1'b1; a8 = 8'h18; b8 = 8'h1C;
      step();
      check("pre-rst c1", 64'(c1), 64'd1);
      check("pre-rst c8", 64'(c8), 64'h18);
      check("pre-rst s8", 64'(s8), 64'h04);
      #2 rst_n = 1'b0;
      #1;
      check_cleared("async rst");
      step();
      rst_n = 1'b1;
      a1 = 1'b0; b1 = 1'b1; a8 = 8'h00; b8 = 8'h5A;
      step();
      check("post-rst ov1", 64'(ov1), 64'd1);
      check("post-rst s1",  64'(s1),  64'd1);
      check("post-rst c1",  64'(c1),  64'd0);
      check("post-rst s8",  64'(s8),  64'h5A);
      check("post-rst ov8", 64'(ov8), 64'd1);

`ifdef HALF_ADDER_STATS_EN
      // Counter: clear, count carry cycles, saturate on the 2-bit instance
      rst_n = 1'b0;
      #1;
      check("cnt rst cnt8", 64'(cnt8), 64'd0);
      v1 = 1'b1; v8 = 1'b1;
      a1 = 1'b1; b1 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      step();
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         check($sformatf("cnt8 #%0d", i), 64'(cnt8), (i < 3) ? 64'(i) : 64'd3);
         check($sformatf("cnt1 #%0d", i), 64'(cnt1), 64'(i));
      end
      v1 = 1'b0; v8 = 1'b0;
      step();
      check("cnt idle cnt8", 64'(cnt8), 64'd3);
      check("cnt idle cnt1", 64'(cnt1), 64'd5);
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
      step();
      check("cnt nocarry cnt1", 64'(cnt1), 64'd5);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
